parking_zone_counter: RTL

Multi-zone successor to the single-zone handicap space counter. Tracks free spaces in `ZONES` independent parking zones, each with its own entry/exit sensors. The block debounces each sensor and converts it to a single-cycle event. It maintains a saturating free-space count per zone with overrun reporting, and drives per-zone and lot-wide green/red indicators. It sits between the raw gate sensors and the display/gate-control logic.

---
 rtl/parking_pkg.sv | 15 +
 rtl/debounce_edge.sv | 41 ++++
 rtl/parking_zone_counter.sv | 92 +++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// parking_pkg: shared defaults and helpers for the parking zone counter
package parking_pkg;

    localparam int DEFAULT_CAPACITY   = 5;
    localparam int DEFAULT_DEB_CYCLES = 4;

    function automatic int cnt_width(input int capacity);
        return $clog2(capacity + 1);
    endfunction

    function automatic int zone_lsb(input int zone, input int width);
        return zone * width;
    endfunction

endpackage

// File: rtl/debounce_edge.sv
// debounce_edge: synchronise one raw sensor bit, debounce it and pulse on accepted rising level
module debounce_edge
    import parking_pkg::*;
#(
    parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int SW = $clog2(DEB_CYCLES + 1);
    localparam logic [SW-1:0] FULL = SW'(DEB_CYCLES);

    logic          s1;
    logic          s2;
    logic [SW-1:0] run;
    logic          flip;

    assign flip = run == FULL;

    // two-stage synchroniser, run length of samples disagreeing with the level, flip and rise pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            run   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            run   <= (flip || s2 == level) ? '0 : run + 1'b1;
            level <= level ^ flip;
            rise  <= flip & ~level;
        end
    end

endmodule

// File: rtl/parking_zone_counter.sv
// parking_zone_counter: per-zone saturating free-space counters fed by debounced gate sensors
module parking_zone_counter
    import parking_pkg::*;
#(
    parameter int ZONES      = 2,
    parameter int CAPACITY   = DEFAULT_CAPACITY,
    parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES,
    parameter int CNT_W      = cnt_width(CAPACITY)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ZONES-1:0]                    entry0,
    input  logic [ZONES-1:0]                    exit0,
    output logic [ZONES*CNT_W-1:0]              free_spaces,
    output logic [ZONES-1:0]                    zone_green,
    output logic [ZONES-1:0]                    zone_red,
    output logic [ZONES-1:0]                    reject,
    output logic [ZONES-1:0]                    underflow,
    output logic [CNT_W+$clog2(ZONES+1)-1:0]    total_free,
    output logic                                lot_full
);

    localparam int TW = CNT_W + $clog2(ZONES + 1);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    logic [ZONES-1:0] ent_ev;
    logic [ZONES-1:0] ext_ev;
    logic [ZONES-1:0] ent_level_unused;
    logic [ZONES-1:0] ext_level_unused;
    logic [TW-1:0]    sum;

    for (genvar z = 0; z < ZONES; z++) begin : g_zone
        logic [CNT_W-1:0] c;
        logic             r;
        logic             u;
        logic             e;
        logic             x;

        debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_ent (
            .clk   (clk),
            .reset (reset),
            .raw   (entry0[z]),
            .level (ent_level_unused[z]),
            .rise  (ent_ev[z])
        );

        debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_ext (
            .clk   (clk),
            .reset (reset),
            .raw   (exit0[z]),
            .level (ext_level_unused[z]),
            .rise  (ext_ev[z])
        );

        assign e = ent_ev[z] & ~ext_ev[z];
        assign x = ext_ev[z] & ~ent_ev[z];

        // saturating count; coincident entry and exit cancel with no side effects
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                c <= CAP;
                r <= 1'b0;
                u <= 1'b0;
            end else begin
                c <= e ? (c == '0 ? c : c - 1'b1) : x ? (c == CAP ? c : c + 1'b1) : c;
                r <= e && c == '0;
                u <= u | (x && c == CAP);
            end
        end

        assign free_spaces[zone_lsb(z, CNT_W) +: CNT_W] = c;
        assign zone_green[z] = c != '0;
        assign zone_red[z]   = c == '0;
        assign reject[z]     = r;
        assign underflow[z]  = u;
    end

    // lot-wide sum of the registered zone counts
    always_comb begin
        sum = '0;
        for (int i = 0; i < ZONES; i++) sum = sum + TW'(free_spaces[zone_lsb(i, CNT_W) +: CNT_W]);
    end

    // registered total, one cycle behind the zone counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) total_free <= TW'(ZONES * CAPACITY);
        else       total_free <= sum;
    end

    assign lot_full = total_free == '0;

endmodule
